// File: rtl/count_monitor_3b.sv
// Watches a free-running 3-bit counter: acquires lock on consecutive increments,
// counts 7->0 wraps, flags stalls, and latches an error on any illegal step.
module count_monitor_3b #(
    parameter int WRAP_W    = 8,
    parameter int STALL_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        q,
    input  logic              clr_err,
    output logic              locked,
    output logic              wrap,
    output logic [WRAP_W-1:0] wraps,
    output logic              stall,
    output logic              err
);

    typedef enum logic [1:0] {ACQ, VERIFY, LOCKED, FAULT} state_t;

    localparam logic [3:0]        HOLD_MAX  = 4'(STALL_LIM);
    localparam logic [3:0]        STALL_AT  = 4'(STALL_LIM - 1);
    localparam logic [WRAP_W-1:0] WRAPS_MAX = {WRAP_W{1'b1}};

    state_t            state_reg, state_next;
    logic [2:0]        prev_reg, prev_next;
    logic [3:0]        hold_reg, hold_next;
    logic              locked_reg, locked_next;
    logic              wrap_reg, wrap_next;
    logic [WRAP_W-1:0] wraps_reg, wraps_next;
    logic              stall_reg, stall_next;
    logic              err_reg, err_next;

    logic [2:0] nxt;
    logic [3:0] hold_inc;

    assign nxt      = prev_reg + 3'd1;
    assign hold_inc = (hold_reg < HOLD_MAX) ? hold_reg + 4'd1 : hold_reg;

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        hold_next  = hold_reg;
        wrap_next  = 1'b0;
        wraps_next = wraps_reg;
        stall_next = stall_reg;
        err_next   = err_reg;

        case (state_reg)
            ACQ: begin
                prev_next  = q;
                hold_next  = 4'd0;
                stall_next = 1'b0;
                state_next = VERIFY;
            end
            VERIFY: begin
                prev_next  = q;
                hold_next  = 4'd0;
                stall_next = 1'b0;
                if (q == nxt)
                    state_next = LOCKED;
            end
            LOCKED: begin
                prev_next = q;
                if (q == nxt) begin
                    hold_next  = 4'd0;
                    stall_next = 1'b0;
                    if (prev_reg == 3'd7) begin
                        wrap_next = 1'b1;
                        if (wraps_reg != WRAPS_MAX)
                            wraps_next = wraps_reg + 1'b1;
                    end
                end else if (q == prev_reg) begin
                    // hold_inc counts repeats after the first equal sample
                    hold_next = hold_inc;
                    if (hold_inc >= STALL_AT)
                        stall_next = 1'b1;
                end else begin
                    hold_next  = 4'd0;
                    stall_next = 1'b0;
                    err_next   = 1'b1;
                    state_next = FAULT;
                end
            end
            FAULT: begin
                stall_next = 1'b0;
                err_next   = 1'b1;
                if (clr_err) begin
                    err_next   = 1'b0;
                    state_next = ACQ;
                end
            end
            default: state_next = ACQ;
        endcase

        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ACQ;
            prev_reg   <= 3'd0;
            hold_reg   <= 4'd0;
            locked_reg <= 1'b0;
            wrap_reg   <= 1'b0;
            wraps_reg  <= '0;
            stall_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            prev_reg   <= prev_next;
            hold_reg   <= hold_next;
            locked_reg <= locked_next;
            wrap_reg   <= wrap_next;
            wraps_reg  <= wraps_next;
            stall_reg  <= stall_next;
            err_reg    <= err_next;
        end
    end

    assign locked = locked_reg;
    assign wrap   = wrap_reg;
    assign wraps  = wraps_reg;
    assign stall  = stall_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_count_monitor_3b.sv
// Directed-vector bench: stimulus pushes expected outputs into a queue, a
// monitor pops one entry per clock and compares both the 8-bit and 2-bit instances.
module tb_count_monitor_3b;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] q = 3'd0;
    logic       clr_err = 1'b0;

    logic       locked, wrap, stall, err;
    logic [7:0] wraps;
    logic       locked2, wrap2, stall2, err2;
    logic [1:0] wraps2;

    always #5 clk = ~clk;

    count_monitor_3b #(.WRAP_W(8), .STALL_LIM(4)) dut (
        .clk(clk), .rst(rst), .q(q), .clr_err(clr_err),
        .locked(locked), .wrap(wrap), .wraps(wraps), .stall(stall), .err(err)
    );

    count_monitor_3b #(.WRAP_W(2), .STALL_LIM(4)) dut2 (
        .clk(clk), .rst(rst), .q(q), .clr_err(clr_err),
        .locked(locked2), .wrap(wrap2), .wraps(wraps2), .stall(stall2), .err(err2)
    );

    typedef struct {
        logic [2:0] q;
        logic       l, w, s, e;
        logic [7:0] wr;
        logic [1:0] wr2;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_wraps = 0;

    // Drive one sample and queue the outputs expected after the next rising edge.
    task automatic step(input logic [2:0] qv, input logic clr, input logic r,
                        input logic el, input logic ew, input logic es, input logic ee);
        exp_t x;
        @(negedge clk);
        q = qv;
        clr_err = clr;
        rst = r;
        if (r)
            exp_wraps = 0;
        else if (ew && exp_wraps < 255)
            exp_wraps = exp_wraps + 1;
        x.q = qv; x.l = el; x.w = ew; x.s = es; x.e = ee;
        x.wr = 8'(exp_wraps);
        x.wr2 = (exp_wraps > 3) ? 2'd3 : 2'(exp_wraps);
        sb.push_back(x);
    endtask

    // Locked free-running count; every sample of 0 follows a 7.
    task automatic run_count(input int from, input int to);
        for (int i = from; i <= to; i++)
            step(3'(i % 8), 1'b0, 1'b0, 1'b1, (i % 8) == 0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            vectors++;
            if (locked !== e.l || wrap !== e.w || wraps !== e.wr || stall !== e.s ||
                err !== e.e || wraps2 !== e.wr2 || wrap2 !== e.w || locked2 !== e.l ||
                stall2 !== e.s || err2 !== e.e) begin
                miscompares++;
                $display("FAIL vec %0d q=%0d: got l=%b w=%b wr=%0d s=%b e=%b wr2=%0d w2=%b required l=%b w=%b wr=%0d s=%b e=%b wr2=%0d",
                         vectors, e.q, locked, wrap, wraps, stall, err, wraps2, wrap2,
                         e.l, e.w, e.wr, e.s, e.e, e.wr2);
            end else begin
                $display("vec %0d q=%0d l=%b w=%b wr=%0d s=%b e=%b wr2=%0d ok",
                         vectors, e.q, locked, wrap, wraps, stall, err, wraps2);
            end
        end
    end

    initial begin
        // reset
        step(3'd0, 1'b0, 1'b1, 0, 0, 0, 0);
        step(3'd0, 1'b0, 1'b1, 0, 0, 0, 0);
        // acquire then lock on 0,1
        step(3'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(3'd1, 1'b0, 1'b0, 1, 0, 0, 0);
        // 20 full wraps; the 2-bit instance saturates at 3
        run_count(2, 161);
        run_count(162, 165);
        // stall on held 5
        step(3'd5, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd5, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd5, 1'b0, 1'b0, 1, 0, 1, 0);
        step(3'd5, 1'b0, 1'b0, 1, 0, 1, 0);
        step(3'd6, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd7, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd0, 1'b0, 1'b0, 1, 1, 0, 0);
        step(3'd1, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd2, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd3, 1'b0, 1'b0, 1, 0, 0, 0);
        // bad jump with clr_err held still faults
        step(3'd6, 1'b1, 1'b0, 0, 0, 0, 1);
        step(3'd4, 1'b0, 1'b0, 0, 0, 0, 1);
        step(3'd2, 1'b1, 1'b0, 0, 0, 0, 0);
        step(3'd3, 1'b1, 1'b0, 0, 0, 0, 0);
        step(3'd4, 1'b1, 1'b0, 1, 0, 0, 0);
        step(3'd5, 1'b0, 1'b0, 1, 0, 0, 0);
        // fault, clear, then VERIFY stays on a bad step and locks on 7->0 without wrap
        step(3'd2, 1'b0, 1'b0, 0, 0, 0, 1);
        step(3'd1, 1'b1, 1'b0, 0, 0, 0, 0);
        step(3'd2, 1'b0, 1'b0, 0, 0, 0, 0);
        step(3'd7, 1'b0, 1'b0, 0, 0, 0, 0);
        step(3'd0, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd1, 1'b0, 1'b0, 1, 0, 0, 0);
        // reset mid-run, build up 9 wraps, fault, reset from FAULT
        step(3'd0, 1'b0, 1'b1, 0, 0, 0, 0);
        step(3'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(3'd1, 1'b0, 1'b0, 1, 0, 0, 0);
        run_count(2, 73);
        step(3'd4, 1'b0, 1'b0, 0, 0, 0, 1);
        step(3'd4, 1'b0, 1'b1, 0, 0, 0, 0);
        step(3'd3, 1'b0, 1'b0, 0, 0, 0, 0);
        step(3'd4, 1'b0, 1'b0, 1, 0, 0, 0);
        step(3'd5, 1'b0, 1'b0, 1, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++)
            @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
